// File: rtl/ccsds_turbo_pkg.sv
// ccsds_turbo_pkg: shared types, constants and helpers for the turbo encoder output monitor.
package ccsds_turbo_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mon_state_t;
    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam int FRAME_CNT_W = 16;
    localparam int ERR_CNT_W = 8;
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] max);
        return (v == max) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/ccsds_turbo_out_monitor_crc.sv
// ccsds_crc16_step: one-cycle CRC-16-CCITT update over RATE bits, MSB (bit RATE-1) first.
module ccsds_crc16_step
    import ccsds_turbo_pkg::*;
#(
    parameter int RATE = 2
) (
    input  logic [15:0]     crc_in,
    input  logic [RATE-1:0] din,
    output logic [15:0]     crc_out
);
    always_comb begin
        crc_out = crc_in;
        for (int i = RATE - 1; i >= 0; i--)
            crc_out = {crc_out[14:0], 1'b0} ^ ((crc_out[15] ^ din[i]) ? CRC16_POLY : 16'h0000);
    end
endmodule

// File: rtl/ccsds_turbo_out_monitor.sv
// ccsds_turbo_out_monitor: frame delimiter, counters, gap-timeout checker for the encoder output.
// Define MON_CRC_EN to get a per-frame CRC-16 signature on o_sig; otherwise o_sig stays 0.
module ccsds_turbo_out_monitor
    import ccsds_turbo_pkg::*;
#(
    parameter int K       = 8160,
    parameter int RATE    = 2,
    parameter int TAIL    = 4,
    parameter int GAP_MAX = 64,
    localparam int CW     = $clog2(K + TAIL + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   i_clr,
    input  logic [RATE-1:0]        i_data,
    input  logic                   i_data_valid,
    output logic                   o_frame_start,
    output logic                   o_frame_done,
    output logic [CW-1:0]          o_sym_cnt,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt,
    output logic [ERR_CNT_W-1:0]   o_err_cnt,
    output logic                   o_gap_err,
    output logic [15:0]            o_sig
);
    localparam int N  = K + TAIL;
    localparam int GW = $clog2(GAP_MAX + 1);

    mon_state_t    state, state_n;
    logic [CW-1:0] sym_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic          accept, start, done, abort;

    assign accept = enable & i_data_valid;

    always_comb begin
        state_n = state;
        sym_n   = o_sym_cnt;
        gap_n   = gap_cnt;
        start   = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        if (state == IDLE) begin
            if (accept) begin
                state_n = RUN;
                sym_n   = CW'(1);
                gap_n   = '0;
                start   = 1'b1;
            end
        end else if (!enable) begin
            state_n = IDLE;
            sym_n   = '0;
            gap_n   = '0;
        end else if (accept) begin
            gap_n = '0;
            if (o_sym_cnt == CW'(N - 1)) begin
                state_n = IDLE;
                sym_n   = '0;
                done    = 1'b1;
            end else
                sym_n = o_sym_cnt + CW'(1);
        end else if (gap_cnt == GW'(GAP_MAX - 1)) begin
            state_n = IDLE;
            sym_n   = '0;
            gap_n   = '0;
            abort   = 1'b1;
        end else
            gap_n = gap_cnt + GW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            o_sym_cnt     <= '0;
            gap_cnt       <= '0;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_cnt   <= '0;
            o_err_cnt     <= '0;
            o_gap_err     <= 1'b0;
        end else begin
            state         <= state_n;
            o_sym_cnt     <= sym_n;
            gap_cnt       <= gap_n;
            o_frame_start <= start;
            o_frame_done  <= done;
            // clear takes priority over a same-cycle increment
            o_frame_cnt   <= i_clr ? '0 : done ? sat_inc(o_frame_cnt, 16'hFFFF) : o_frame_cnt;
            o_err_cnt     <= i_clr ? '0 : abort ? ERR_CNT_W'(sat_inc(16'(o_err_cnt), 16'h00FF)) : o_err_cnt;
            o_gap_err     <= !i_clr & (o_gap_err | abort);
        end
    end

`ifdef MON_CRC_EN
    logic [15:0] crc, crc_base, crc_next;

    assign crc_base = (state == IDLE) ? CRC16_INIT : crc;

    ccsds_crc16_step #(.RATE(RATE)) u_crc (
        .crc_in (crc_base),
        .din    (i_data),
        .crc_out(crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            crc   <= CRC16_INIT;
            o_sig <= '0;
        end else begin
            crc   <= (state_n == IDLE) ? CRC16_INIT : accept ? crc_next : crc;
            o_sig <= done ? crc_next : o_sig;
        end
    end
`else
    logic unused_data;

    assign unused_data = ^i_data;
    assign o_sig       = '0;
`endif
endmodule

// File: tb/tb_ccsds_turbo_out_monitor.sv
// tb_ccsds_turbo_out_monitor: directed table-driven bench for the encoder output monitor.
module tb_ccsds_turbo_out_monitor;
    localparam int K = 16, RATE = 2, TAIL = 4, GAP_MAX = 8, CW = 5;

    logic            clk = 1'b0, rst = 1'b1, enable = 1'b0, i_clr = 1'b0, i_data_valid = 1'b0;
    logic [RATE-1:0] i_data = '0;
    logic            o_frame_start, o_frame_done, o_gap_err;
    logic [CW-1:0]   o_sym_cnt;
    logic [15:0]     o_frame_cnt, o_sig, sig_ref;
    logic [7:0]      o_err_cnt;
    int              vectors = 0, miss = 0;

    typedef struct {
        int pre;
        int idle;
        int post;
        int frames;
        int errs;
        int gap;
        int sym;
    } vec_t;
    vec_t tbl[8];

    ccsds_turbo_out_monitor #(.K(K), .RATE(RATE), .TAIL(TAIL), .GAP_MAX(GAP_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .i_clr        (i_clr),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_frame_start(o_frame_start),
        .o_frame_done (o_frame_done),
        .o_sym_cnt    (o_sym_cnt),
        .o_frame_cnt  (o_frame_cnt),
        .o_err_cnt    (o_err_cnt),
        .o_gap_err    (o_gap_err),
        .o_sig        (o_sig)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] crc_model();
        logic [15:0] c = 16'hFFFF;
        logic [1:0]  s = 2'b01;
        for (int n = 0; n < K + TAIL; n++)
            for (int b = 1; b >= 0; b--) begin
                logic fb = c[15] ^ s[b];
                c = c << 1;
                if (fb) c = c ^ 16'h1021;
            end
        return c;
    endfunction

    function automatic int exp_sig(input int frames);
`ifdef MON_CRC_EN
        return (frames > 0) ? int'(sig_ref) : 0;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic v, input logic c);
        @(negedge clk);
        enable       = en;
        i_data_valid = v;
        i_clr        = c;
        i_data       = 2'b01;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; i_data_valid = 1'b0; i_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic accepts(input int n);
        repeat (n) drive(1'b1, 1'b1, 1'b0);
    endtask

    task automatic idles(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"}, int'(o_frame_start), 0);
        chk({tag, "_done"}, int'(o_frame_done), 0);
        chk({tag, "_sym"}, int'(o_sym_cnt), 0);
        chk({tag, "_frames"}, int'(o_frame_cnt), 0);
        chk({tag, "_errs"}, int'(o_err_cnt), 0);
        chk({tag, "_gap"}, int'(o_gap_err), 0);
        chk({tag, "_sig"}, int'(o_sig), 0);
    endtask

    initial begin
        //         pre idle post frames errs gap sym
        tbl[0] = '{20, 0, 0, 1, 0, 0, 0};
        tbl[1] = '{40, 0, 0, 2, 0, 0, 0};
        tbl[2] = '{10, 8, 0, 0, 1, 1, 0};
        tbl[3] = '{10, 7, 10, 1, 0, 0, 0};
        tbl[4] = '{10, 8, 20, 1, 1, 1, 0};
        tbl[5] = '{5, 0, 0, 0, 0, 0, 5};
        tbl[6] = '{10, 8, 3, 0, 1, 1, 3};
        tbl[7] = '{25, 0, 0, 1, 0, 0, 5};
        sig_ref = crc_model();

        do_reset();
        chk_zero("reset");

        for (int i = 0; i < 8; i++) begin
            do_reset();
            accepts(tbl[i].pre);
            idles(tbl[i].idle);
            accepts(tbl[i].post);
            drive(1'b0, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_frames", i), int'(o_frame_cnt), tbl[i].frames);
            chk($sformatf("tbl%0d_errs", i), int'(o_err_cnt), tbl[i].errs);
            chk($sformatf("tbl%0d_gap", i), int'(o_gap_err), tbl[i].gap);
            chk($sformatf("tbl%0d_sym", i), int'(o_sym_cnt), tbl[i].sym);
            chk($sformatf("tbl%0d_sig", i), int'(o_sig), exp_sig(tbl[i].frames));
        end

        // pulse timing over two contiguous frames
        do_reset();
        for (int i = 0; i < 42; i++) begin
            drive(1'b1, i < 40, 1'b0);
            chk($sformatf("pulse_start_c%0d", i), int'(o_frame_start), int'(i == 1 || i == 21));
            chk($sformatf("pulse_done_c%0d", i), int'(o_frame_done), int'(i == 20 || i == 40));
        end

        // valid while disabled is ignored
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            chk("dis_start", int'(o_frame_start), 0);
            chk("dis_sym", int'(o_sym_cnt), 0);
        end

        // enable drop mid-frame: silent abort
        do_reset();
        accepts(5);
        drive(1'b0, 1'b1, 1'b0);
        chk("drop_sym_before", int'(o_sym_cnt), 5);
        drive(1'b0, 1'b0, 1'b0);
        chk("drop_sym", int'(o_sym_cnt), 0);
        chk("drop_errs", int'(o_err_cnt), 0);
        chk("drop_gap", int'(o_gap_err), 0);

        // clear coincident with frame_done
        do_reset();
        accepts(20);
        drive(1'b0, 1'b0, 1'b0);
        chk("clrdone_first", int'(o_frame_cnt), 1);
        accepts(19);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("clrdone_pulse", int'(o_frame_done), 1);
        chk("clrdone_frames", int'(o_frame_cnt), 0);

        // clear mid-frame: frame in progress still completes
        do_reset();
        accepts(25);
        drive(1'b1, 1'b1, 1'b1);
        accepts(14);
        drive(1'b0, 1'b0, 1'b0);
        chk("clrmid_frames", int'(o_frame_cnt), 1);
        chk("clrmid_sig", int'(o_sig), exp_sig(1));

        // clear of sticky gap error
        do_reset();
        accepts(3);
        idles(8);
        drive(1'b0, 1'b0, 1'b1);
        chk("clrgap_set", int'(o_gap_err), 1);
        drive(1'b0, 1'b0, 1'b0);
        chk("clrgap_gap", int'(o_gap_err), 0);
        chk("clrgap_errs", int'(o_err_cnt), 0);

        // reset in the middle of a frame
        do_reset();
        accepts(20);
        accepts(12);
        @(negedge clk);
        rst = 1'b1; enable = 1'b1; i_data_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; enable = 1'b0; i_data_valid = 1'b0;
        chk_zero("midrst");
        accepts(20);
        drive(1'b0, 1'b0, 1'b0);
        chk("midrst_frames", int'(o_frame_cnt), 1);
        chk("midrst_sig", int'(o_sig), exp_sig(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end
endmodule
